// File: rtl/rv32i_hazard_unit_if.sv
// Pipeline <-> hazard-unit bundle: stall/redirect/ID operand info in, pipe-register
// control, EX forwarding selects and performance counters out.
interface rv32i_hazard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_W     = 32
);
  logic                  imem_busy;
  logic                  dmem_busy;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_wr;
  logic                  id_is_load;
  logic                  redirect;
  logic                  load_pipe;
  logic                  flush_ifid;
  logic                  bubble_idex;
  logic                  hold_pc;
  logic [1:0]            fwd_sel1;
  logic [1:0]            fwd_sel2;
  logic [PERF_W-1:0]     perf_stall;
  logic [PERF_W-1:0]     perf_bubble;
  logic [PERF_W-1:0]     perf_flush;

  modport master (
    output imem_busy, dmem_busy, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_wr, id_is_load, redirect,
    input  load_pipe, flush_ifid, bubble_idex, hold_pc, fwd_sel1, fwd_sel2,
           perf_stall, perf_bubble, perf_flush
  );

  modport slave (
    input  imem_busy, dmem_busy, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_wr, id_is_load, redirect,
    output load_pipe, flush_ifid, bubble_idex, hold_pc, fwd_sel1, fwd_sel2,
           perf_stall, perf_bubble, perf_flush
  );
endinterface

// File: rtl/rv32i_hazard_unit.sv
// Hazard/pipe control for the 5-stage RV32I pipeline: freeze, redirect flush, load-use
// bubble, EX forwarding. Define HAZARD_PERF_CNT_EN to build the saturating perf counters.
module rv32i_hazard_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int FLUSH_DEPTH = 2,
  parameter int PERF_W      = 32
) (
  input logic               clk,
  input logic               reset,
  rv32i_hazard_unit_if.slave hz
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } ex_entry_t;

  // Past EX only the write-back identity matters for forwarding.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr;
  } wb_entry_t;

  ex_entry_t ex_reg,  ex_next;
  wb_entry_t mem_reg, mem_next;
  wb_entry_t wb_reg,  wb_next;
  logic      redirect_pend_reg, redirect_pend_next;

  logic freeze;
  logic redirect_any;
  logic load_use;
  logic load_pipe_int;
  logic flush_ifid_int;
  logic bubble_idex_int;
  logic hold_pc_int;
  logic service_redirect;
  logic insert_bubble;

  always_comb begin
    freeze       = hz.imem_busy | hz.dmem_busy;
    redirect_any = hz.redirect | redirect_pend_reg;
    load_use     = ex_reg.valid & ex_reg.is_load & (ex_reg.rd != '0) &
                   ((hz.id_use_rs1 & (hz.id_rs1 == ex_reg.rd)) |
                    (hz.id_use_rs2 & (hz.id_rs2 == ex_reg.rd)));
    service_redirect = !freeze & redirect_any;
    insert_bubble    = !freeze & !redirect_any & load_use;
  end

  // Freeze outranks redirect, redirect outranks load-use.
  always_comb begin
    load_pipe_int   = 1'b1;
    flush_ifid_int  = 1'b0;
    bubble_idex_int = 1'b0;
    hold_pc_int     = 1'b0;
    if (reset) begin
      flush_ifid_int  = 1'b1;
      bubble_idex_int = 1'b1;
    end else if (freeze) begin
      load_pipe_int = 1'b0;
      hold_pc_int   = 1'b1;
    end else if (service_redirect) begin
      flush_ifid_int  = 1'b1;
      bubble_idex_int = (FLUSH_DEPTH == 2);
    end else if (insert_bubble) begin
      hold_pc_int     = 1'b1;
      bubble_idex_int = 1'b1;
    end
  end

  always_comb begin
    ex_next            = ex_reg;
    mem_next           = mem_reg;
    wb_next            = wb_reg;
    redirect_pend_next = redirect_pend_reg;
    if (load_pipe_int) begin
      wb_next  = mem_reg;
      mem_next = '{valid: ex_reg.valid, rd: ex_reg.rd, wr: ex_reg.wr};
      if (bubble_idex_int) begin
        ex_next = '0;
      end else begin
        ex_next = '{valid: 1'b1, rd: hz.id_rd, wr: hz.id_wr, is_load: hz.id_is_load,
                    rs1: hz.id_rs1, rs2: hz.id_rs2};
      end
      redirect_pend_next = 1'b0;
    end else if (hz.redirect) begin
      redirect_pend_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_reg            <= '0;
      mem_reg           <= '0;
      wb_reg            <= '0;
      redirect_pend_reg <= 1'b0;
    end else begin
      ex_reg            <= ex_next;
      mem_reg           <= mem_next;
      wb_reg            <= wb_next;
      redirect_pend_reg <= redirect_pend_next;
    end
  end

  logic [REG_ADDR_W-1:0] ex_src [2];
  logic [1:0]            fwd_sel [2];

  assign ex_src[0] = ex_reg.rs1;
  assign ex_src[1] = ex_reg.rs2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic mem_hit;
      logic wb_hit;
      assign mem_hit = mem_reg.valid & mem_reg.wr & (mem_reg.rd != '0) & (mem_reg.rd == ex_src[gi]);
      assign wb_hit  = wb_reg.valid  & wb_reg.wr  & (wb_reg.rd  != '0) & (wb_reg.rd  == ex_src[gi]);
      assign fwd_sel[gi] = (reset || !ex_reg.valid) ? 2'b00 :
                           mem_hit                  ? 2'b01 :
                           wb_hit                   ? 2'b10 : 2'b00;
    end
  endgenerate

  assign hz.load_pipe   = load_pipe_int;
  assign hz.flush_ifid  = flush_ifid_int;
  assign hz.bubble_idex = bubble_idex_int;
  assign hz.hold_pc     = hold_pc_int;
  assign hz.fwd_sel1    = fwd_sel[0];
  assign hz.fwd_sel2    = fwd_sel[1];

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] perf_stall_reg;
  logic [PERF_W-1:0] perf_bubble_reg;
  logic [PERF_W-1:0] perf_flush_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_reg  <= '0;
      perf_bubble_reg <= '0;
      perf_flush_reg  <= '0;
    end else begin
      if (!load_pipe_int && (perf_stall_reg != '1))
        perf_stall_reg <= perf_stall_reg + 1'b1;
      if (insert_bubble && (perf_bubble_reg != '1))
        perf_bubble_reg <= perf_bubble_reg + 1'b1;
      if (service_redirect && (perf_flush_reg != '1))
        perf_flush_reg <= perf_flush_reg + 1'b1;
    end
  end

  assign hz.perf_stall  = perf_stall_reg;
  assign hz.perf_bubble = perf_bubble_reg;
  assign hz.perf_flush  = perf_flush_reg;
`else
  assign hz.perf_stall  = {PERF_W{1'b0}};
  assign hz.perf_bubble = {PERF_W{1'b0}};
  assign hz.perf_flush  = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_rv32i_hazard_unit.sv
// Directed + randomized bench for rv32i_hazard_unit against an in-flight instruction
// list model; perf counters are checked when HAZARD_PERF_CNT_EN is defined.
module tb_rv32i_hazard_unit;
  localparam int RAW = 5;
  localparam int FD  = 2;
  localparam int PW  = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv32i_hazard_unit_if #(.REG_ADDR_W(RAW), .PERF_W(PW)) hz ();

  rv32i_hazard_unit #(.REG_ADDR_W(RAW), .FLUSH_DEPTH(FD), .PERF_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  typedef struct packed {
    logic           valid;
    logic [RAW-1:0] rd;
    logic           wr;
    logic           ld;
    logic [RAW-1:0] rs1;
    logic [RAW-1:0] rs2;
  } instr_t;

  // pipe_q[0] = instruction in EX, [1] = MEM, [2] = WB
  instr_t      pipe_q[$];
  logic        pend_m;
  int unsigned m_stall, m_bubble, m_flush;
  int          n_vec = 0;
  int          n_err = 0;

  logic       e_lp, e_fl, e_bb, e_hp;
  logic [1:0] e_f1, e_f2;
  logic       m_freeze, m_red, m_lu;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] producer_of(input logic [RAW-1:0] src);
    for (int k = 1; k <= 2; k++)
      if (pipe_q[k].valid && pipe_q[k].wr && pipe_q[k].rd != 0 && pipe_q[k].rd == src)
        return (k == 1) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  task automatic model_clear();
    pipe_q.delete();
    for (int k = 0; k < 3; k++) pipe_q.push_back('0);
    pend_m   = 1'b0;
    m_stall  = 0;
    m_bubble = 0;
    m_flush  = 0;
  endtask

  task automatic model_outputs();
    instr_t ex;
    ex       = pipe_q[0];
    m_freeze = hz.imem_busy || hz.dmem_busy;
    m_red    = hz.redirect || pend_m;
    m_lu     = ex.valid && ex.ld && ex.rd != 0 &&
               ((hz.id_use_rs1 && hz.id_rs1 == ex.rd) || (hz.id_use_rs2 && hz.id_rs2 == ex.rd));
    {e_lp, e_fl, e_bb, e_hp, e_f1, e_f2} = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    if (reset) begin
      e_fl = 1'b1;
      e_bb = 1'b1;
    end else begin
      if (m_freeze) begin
        e_lp = 1'b0;
        e_hp = 1'b1;
      end else if (m_red) begin
        e_fl = 1'b1;
        e_bb = (FD == 2);
      end else if (m_lu) begin
        e_hp = 1'b1;
        e_bb = 1'b1;
      end
      if (ex.valid) begin
        e_f1 = producer_of(ex.rs1);
        e_f2 = producer_of(ex.rs2);
      end
    end
  endtask

  task automatic model_update();
    instr_t nw;
    if (reset) begin
      model_clear();
    end else if (!e_lp) begin
      if (m_stall != 32'hFFFF_FFFF) m_stall++;
      if (hz.redirect) pend_m = 1'b1;
    end else begin
      nw = '0;
      if (!e_bb) nw = '{1'b1, hz.id_rd, hz.id_wr, hz.id_is_load, hz.id_rs1, hz.id_rs2};
      pipe_q.push_front(nw);
      void'(pipe_q.pop_back());
      if (m_red) m_flush++;
      else if (m_lu) m_bubble++;
      pend_m = 1'b0;
    end
  endtask

  task automatic cyc();
    logic [31:0] ps, pb, pf;
    @(negedge clk);
    model_outputs();
`ifdef HAZARD_PERF_CNT_EN
    ps = m_stall; pb = m_bubble; pf = m_flush;
`else
    ps = 0; pb = 0; pf = 0;
`endif
    chk("load_pipe",   32'(hz.load_pipe),   32'(e_lp));
    chk("flush_ifid",  32'(hz.flush_ifid),  32'(e_fl));
    chk("bubble_idex", 32'(hz.bubble_idex), 32'(e_bb));
    chk("hold_pc",     32'(hz.hold_pc),     32'(e_hp));
    chk("fwd_sel1",    32'(hz.fwd_sel1),    32'(e_f1));
    chk("fwd_sel2",    32'(hz.fwd_sel2),    32'(e_f2));
    chk("perf_stall",  hz.perf_stall,       ps);
    chk("perf_bubble", hz.perf_bubble,      pb);
    chk("perf_flush",  hz.perf_flush,       pf);
    $display("t=%0t rst=%0b ib=%0b db=%0b red=%0b id(rs1=%0d/%0b rs2=%0d/%0b rd=%0d wr=%0b ld=%0b) -> lp=%0b fl=%0b bb=%0b hp=%0b f1=%0d f2=%0d",
             $time, reset, hz.imem_busy, hz.dmem_busy, hz.redirect, hz.id_rs1, hz.id_use_rs1,
             hz.id_rs2, hz.id_use_rs2, hz.id_rd, hz.id_wr, hz.id_is_load, hz.load_pipe,
             hz.flush_ifid, hz.bubble_idex, hz.hold_pc, hz.fwd_sel1, hz.fwd_sel2);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic ib, input logic db, input logic red);
    hz.imem_busy = ib;
    hz.dmem_busy = db;
    hz.redirect  = red;
  endtask

  task automatic set_id(input int rs1, input logic u1, input int rs2, input logic u2,
                        input int rd, input logic wr, input logic ld);
    hz.id_rs1     = RAW'(rs1);
    hz.id_use_rs1 = u1;
    hz.id_rs2     = RAW'(rs2);
    hz.id_use_rs2 = u2;
    hz.id_rd      = RAW'(rd);
    hz.id_wr      = wr;
    hz.id_is_load = ld;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_clear();
    reset = 1'b1;
    set_ctl(0, 0, 0);
    idle();
    cyc();
    cyc();
    reset = 1'b0;
    cyc();

    // x1 producer followed by consumers: MEM then WB forwarding
    set_id(0, 0, 0, 0, 1, 1, 0); cyc();
    set_id(1, 1, 0, 0, 2, 1, 0); cyc();
    set_id(1, 1, 0, 0, 3, 1, 0); cyc();
    idle(); cyc(); cyc();

    // load-use on rs2 = x5: one bubble, then WB forward
    set_id(0, 0, 0, 0, 5, 1, 1); cyc();
    set_id(0, 0, 5, 1, 6, 1, 0); cyc(); cyc(); cyc();
    idle(); cyc(); cyc();

    // redirect during dmem freeze, serviced from pending on the 4th cycle
    set_ctl(0, 1, 1); cyc(); cyc(); cyc();
    set_ctl(0, 0, 0); cyc(); cyc();

    // x0 never forwards; duplicate x7 in MEM and WB prefers MEM
    set_id(0, 0, 0, 0, 0, 1, 0); cyc();
    set_id(0, 1, 0, 0, 8, 0, 0); cyc();
    set_id(0, 0, 0, 0, 7, 1, 0); cyc(); cyc();
    set_id(7, 1, 7, 1, 9, 1, 0); cyc();
    idle(); cyc(); cyc();

    // redirect and load-use together: redirect wins, no bubble counted
    set_id(0, 0, 0, 0, 5, 1, 1); cyc();
    set_id(5, 1, 0, 0, 4, 1, 0); set_ctl(0, 0, 1); cyc();
    set_ctl(0, 0, 0); idle(); cyc(); cyc();

    // reset during imem freeze with a pending redirect discards it
    set_ctl(1, 0, 1); cyc();
    set_ctl(1, 0, 0); cyc();
    reset = 1'b1; cyc();
    reset = 1'b0; set_ctl(0, 0, 0); cyc(); cyc();

    // randomized traffic with a small register pool to provoke hazards
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      set_ctl($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      set_id($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $urandom_range(0, 2) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
